// File: rtl/sad3_min_tracker.sv
// Final SAD stage: reduces four partial SADs to one candidate score and tracks
// the minimum SAD and its index across one search window.
module sad3_min_tracker #(
  parameter int NUM_CANDIDATES = 16,
  parameter int IDX_W          = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             InValid,
  input  logic [31:0]      A2,
  input  logic [31:0]      B2,
  input  logic [31:0]      C2,
  input  logic [31:0]      D2,
  output logic [31:0]      oSAD,
  output logic             oSADValid,
  output logic [31:0]      oMinSAD,
  output logic [IDX_W-1:0] oMinIndex,
  output logic             oBusy,
  output logic             oDone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUM_CANDIDATES - 1);

  state_t           state;
  logic [IDX_W-1:0] count;
  logic [33:0]      sumWide;
  logic [31:0]      candSum;

  // Two guard bits hold every possible carry of a four-way 32-bit add.
  always_comb begin
    sumWide = {2'b00, A2} + {2'b00, B2} + {2'b00, C2} + {2'b00, D2};
    candSum = (|sumWide[33:32]) ? 32'hFFFF_FFFF : sumWide[31:0];
  end

  // Start wins in every state, so a restart drops any candidate arriving with it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      count     <= '0;
      oSAD      <= '0;
      oSADValid <= 1'b0;
      oMinSAD   <= 32'hFFFF_FFFF;
      oMinIndex <= '0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      oSADValid <= 1'b0;
      oDone     <= 1'b0;
      if (Start) begin
        state     <= ACCUM;
        count     <= '0;
        oMinSAD   <= 32'hFFFF_FFFF;
        oMinIndex <= '0;
        oBusy     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            oBusy <= 1'b0;
          end
          ACCUM: begin
            if (InValid) begin
              oSAD      <= candSum;
              oSADValid <= 1'b1;
              if (candSum < oMinSAD) begin
                oMinSAD   <= candSum;
                oMinIndex <= count;
              end
              if (count == LAST_INDEX) begin
                state <= DONE;
                oDone <= 1'b1;
                oBusy <= 1'b0;
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
          default: begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sad3_min_tracker.sv
// Scoreboard bench for sad3_min_tracker: directed candidates push hand-computed
// results into a queue that a negedge monitor drains whenever oSADValid is high.
module tb_sad3_min_tracker;

  localparam int N   = 4;
  localparam int IW  = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          InValid = 1'b0;
  logic [31:0]   A2 = '0, B2 = '0, C2 = '0, D2 = '0;
  logic [31:0]   oSAD, oMinSAD;
  logic          oSADValid, oBusy, oDone;
  logic [IW-1:0] oMinIndex;

  typedef struct {
    logic [31:0] sad;
    logic [31:0] minSad;
    logic [31:0] minIdx;
    logic        done;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  sad3_min_tracker #(.NUM_CANDIDATES(N), .IDX_W(IW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid),
    .A2(A2), .B2(B2), .C2(C2), .D2(D2),
    .oSAD(oSAD), .oSADValid(oSADValid), .oMinSAD(oMinSAD),
    .oMinIndex(oMinIndex), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic idleCycle();
    @(posedge Clk); #1;
    Start = 1'b0; InValid = 1'b0;
    A2 = '0; B2 = '0; C2 = '0; D2 = '0;
  endtask

  task automatic pulseStart(input logic withValid);
    @(posedge Clk); #1;
    Start = 1'b1; InValid = withValid;
    A2 = 32'd1; B2 = 32'd1; C2 = 32'd1; D2 = 32'd1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d,
                               input logic [31:0] expSad, input logic [31:0] expMin,
                               input logic [31:0] expIdx, input logic expDone);
    exp_t e;
    @(posedge Clk); #1;
    Start = 1'b0; InValid = 1'b1;
    A2 = a; B2 = b; C2 = c; D2 = d;
    e.sad = expSad; e.minSad = expMin; e.minIdx = expIdx; e.done = expDone;
    expQ.push_back(e);
  endtask

  // Monitor: every oSADValid must match the oldest expected entry.
  always @(negedge Clk) begin
    if (oSADValid) begin
      if (expQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpectedValid: got oSAD=%h expected no output", oSAD);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sad", oSAD, e.sad);
        checkOutput("minSad", oMinSAD, e.minSad);
        checkOutput("minIdx", {24'd0, oMinIndex}, e.minIdx);
        checkOutput("doneWithValid", {31'd0, oDone}, {31'd0, e.done});
      end
    end else if (oDone) begin
      checks++; errors++;
      $display("[TB] FAIL strayDone: got oDone=1 expected 0 without oSADValid");
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkOutput("rstSad", oSAD, 32'd0);
    checkOutput("rstValid", {31'd0, oSADValid}, 32'd0);
    checkOutput("rstMin", oMinSAD, 32'hFFFF_FFFF);
    checkOutput("rstIdx", {24'd0, oMinIndex}, 32'd0);
    checkOutput("rstBusy", {31'd0, oBusy}, 32'd0);
    checkOutput("rstDone", {31'd0, oDone}, 32'd0);
    @(posedge Clk); #1 Reset = 1'b1;

    // IDLE ignores InValid, including alongside Start
    @(posedge Clk); #1 InValid = 1'b1; A2 = 32'd7;
    @(posedge Clk); #1 InValid = 1'b1; A2 = 32'd9;
    idleCycle();
    checkOutput("idleBusy", {31'd0, oBusy}, 32'd0);
    pulseStart(1'b1);

    // Basic window with a tie at the minimum
    applyStimulus(32'd25, 32'd25, 32'd25, 32'd25, 32'd100, 32'd100, 32'd0, 1'b0);
    applyStimulus(32'd10, 32'd10, 32'd10, 32'd10, 32'd40,  32'd40,  32'd1, 1'b0);
    applyStimulus(32'd10, 32'd20, 32'd30, 32'd10, 32'd70,  32'd40,  32'd1, 1'b0);
    applyStimulus(32'd0,  32'd0,  32'd0,  32'd40, 32'd40,  32'd40,  32'd1, 1'b1);
    idleCycle();
    checkOutput("doneBusy", {31'd0, oBusy}, 32'd0);
    checkOutput("donePulse", {31'd0, oDone}, 32'd1);
    idleCycle();
    checkOutput("holdMin", oMinSAD, 32'd40);
    checkOutput("holdIdx", {24'd0, oMinIndex}, 32'd1);
    checkOutput("holdSad", oSAD, 32'd40);
    checkOutput("doneOnce", {31'd0, oDone}, 32'd0);

    // Saturation, including a sum of exactly 2^32
    pulseStart(1'b0);
    applyStimulus(32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
    applyStimulus(32'd1, 32'd1, 32'd1, 32'd2, 32'd5, 32'd5, 32'd1, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1,
                  32'hFFFF_FFFF, 32'd5, 32'd1, 1'b0);
    applyStimulus(32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0,
                  32'hFFFF_FFFE, 32'd5, 32'd1, 1'b1);
    idleCycle();

    // Gapped input: busy holds across idle cycles
    pulseStart(1'b0);
    applyStimulus(32'd50, 32'd0, 32'd0, 32'd0, 32'd50, 32'd50, 32'd0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      idleCycle();
      checkOutput("gapBusy", {31'd0, oBusy}, 32'd1);
    end
    applyStimulus(32'd0, 32'd60, 32'd0, 32'd0, 32'd60, 32'd50, 32'd0, 1'b0);
    for (int g = 0; g < 3; g++) idleCycle();
    applyStimulus(32'd0, 32'd0, 32'd20, 32'd0, 32'd20, 32'd20, 32'd2, 1'b0);
    for (int g = 0; g < 3; g++) idleCycle();
    applyStimulus(32'd5, 32'd5, 32'd5, 32'd5, 32'd20, 32'd20, 32'd2, 1'b1);
    idleCycle();
    checkOutput("gapDoneBusy", {31'd0, oBusy}, 32'd0);
    idleCycle();

    // Restart with Start+InValid at count 2
    pulseStart(1'b0);
    applyStimulus(32'd30, 32'd0, 32'd0, 32'd0, 32'd30, 32'd30, 32'd0, 1'b0);
    applyStimulus(32'd10, 32'd0, 32'd0, 32'd0, 32'd10, 32'd10, 32'd1, 1'b0);
    pulseStart(1'b1);
    idleCycle();
    checkOutput("restartMin", oMinSAD, 32'hFFFF_FFFF);
    checkOutput("restartIdx", {24'd0, oMinIndex}, 32'd0);
    checkOutput("restartBusy", {31'd0, oBusy}, 32'd1);
    applyStimulus(32'd9, 32'd0, 32'd0, 32'd0, 32'd9, 32'd9, 32'd0, 1'b0);
    applyStimulus(32'd8, 32'd0, 32'd0, 32'd0, 32'd8, 32'd8, 32'd1, 1'b0);
    applyStimulus(32'd4, 32'd4, 32'd0, 32'd0, 32'd8, 32'd8, 32'd1, 1'b0);
    applyStimulus(32'd7, 32'd0, 32'd0, 32'd0, 32'd7, 32'd7, 32'd3, 1'b1);

    // Start during the DONE cycle, then reset mid-window
    pulseStart(1'b0);
    applyStimulus(32'd3, 32'd3, 32'd3, 32'd3, 32'd12, 32'd12, 32'd0, 1'b0);
    applyStimulus(32'd2, 32'd2, 32'd2, 32'd5, 32'd11, 32'd11, 32'd1, 1'b0);
    idleCycle();
    checkOutput("restartFromDoneBusy", {31'd0, oBusy}, 32'd1);
    @(negedge Clk); #1;
    Reset = 1'b0;
    #1;
    checkOutput("midRstSad", oSAD, 32'd0);
    checkOutput("midRstMin", oMinSAD, 32'hFFFF_FFFF);
    checkOutput("midRstIdx", {24'd0, oMinIndex}, 32'd0);
    checkOutput("midRstBusy", {31'd0, oBusy}, 32'd0);
    checkOutput("midRstDone", {31'd0, oDone}, 32'd0);
    idleCycle();
    idleCycle();
    Reset = 1'b1;
    for (int g = 0; g < 4; g++) idleCycle();
    checkOutput("postRstBusy", {31'd0, oBusy}, 32'd0);
    checkOutput("queueEmpty", expQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
